oob_dev: RTL and testbench

- Device-side OOB responder: the far end of the host OOB initiator in the SATA PHY.
- Detects host COMRESET and answers with COMINIT, then waits for host COMWAKE and answers with COMWAKE.
- Transmits ALIGNp until it locks to the host ALIGNp stream, then sends SYNCp and declares the link up.
- Sits between the device link layer and the GTX wrapper; used for device emulation and host loopback testing.

---
 rtl/oob_dev.sv | 161 ++++++++++++++++
 tb/tb_oob_dev.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oob_dev.sv
// oob_dev: SATA device-side OOB responder (COMRESET->COMINIT, COMWAKE->COMWAKE, ALIGNp/SYNCp lock).
// Define OOB_DEV_DEBUG_EN to populate the debug status word with state and event counters.
module oob_dev #(
  parameter int DATA_BYTE_WIDTH  = 4,
  parameter int CLK_SPEED_GRADE  = 1,
  parameter int TIMEOUT_CYCLES   = 66000,
  parameter int IDLE_LOSS_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         gtx_ready,
  input  logic                         rxcominitdet_in,
  input  logic                         rxcomwakedet_in,
  input  logic                         rxelecidle_in,
  output logic                         txcominit,
  output logic                         txcomwake,
  output logic                         txelecidle,
  input  logic [DATA_BYTE_WIDTH*8-1:0] txdata_in,
  input  logic [DATA_BYTE_WIDTH-1:0]   txcharisk_in,
  output logic [DATA_BYTE_WIDTH*8-1:0] txdata_out,
  output logic [DATA_BYTE_WIDTH-1:0]   txcharisk_out,
  input  logic [DATA_BYTE_WIDTH*8-1:0] rxdata_in,
  input  logic [DATA_BYTE_WIDTH-1:0]   rxcharisk_in,
  input  logic                         rxbyteisaligned,
  output logic                         link_up,
  output logic                         link_down,
  output logic                         oob_error,
  output logic                         phy_ready,
  output logic [11:0]                  debug
);

  localparam int DW = DATA_BYTE_WIDTH * 8;
  localparam int IW = $clog2(IDLE_LOSS_CYCLES + 1);
  localparam logic [19:0] LIMIT = 20'(TIMEOUT_CYCLES * CLK_SPEED_GRADE);
  localparam logic [DW-1:0] ALIGNP = DW'(32'h7B4A4ABC);
  localparam logic [DW-1:0] SYNCP  = DW'(32'hB5B5957C);
  localparam logic [DATA_BYTE_WIDTH-1:0] K_PRIM = DATA_BYTE_WIDTH'(4'b0001);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_COMINIT    = 4'd1,
    S_WAIT_WAKE  = 4'd2,
    S_COMWAKE    = 4'd3,
    S_WAIT_QUIET = 4'd4,
    S_ALIGN      = 4'd5,
    S_SYNC       = 4'd6,
    S_READY      = 4'd7
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [19:0]           r_cnt;
  logic [1:0]            r_sync_cnt;
  logic [IW-1:0]         r_idle_cnt;
  logic                  w_waiting;
  logic                  w_timeout;
  logic                  w_timeout_evt;
  logic                  w_abort;
  state_t                w_abort_st;
  logic                  w_rx_align;
  logic                  w_prim_nonalign;
  logic                  w_idle_loss;

  assign w_waiting       = (r_state inside {S_WAIT_WAKE, S_WAIT_QUIET, S_ALIGN, S_SYNC});
  assign w_timeout       = w_waiting && (r_cnt == LIMIT - 20'd1);
  assign w_rx_align      = rxbyteisaligned && (rxdata_in == ALIGNP) && (rxcharisk_in == K_PRIM);
  assign w_prim_nonalign = (rxcharisk_in == K_PRIM) && (rxdata_in != ALIGNP);
  assign w_idle_loss     = rxelecidle_in && (r_idle_cnt == IW'(IDLE_LOSS_CYCLES - 1));
  // A repeated COMRESET outranks everything, then loss of the GTX.
  assign w_abort         = rxcominitdet_in || !gtx_ready;
  assign w_abort_st      = rxcominitdet_in ? S_COMINIT : S_IDLE;

  always_comb begin
    w_next        = r_state;
    w_timeout_evt = 1'b0;
    case (r_state)
      S_IDLE:       if (gtx_ready && rxcominitdet_in) w_next = S_COMINIT;
      S_COMINIT:    w_next = gtx_ready ? S_WAIT_WAKE : S_IDLE;
      S_WAIT_WAKE:  if (w_abort) w_next = w_abort_st;
                    else if (rxcomwakedet_in) w_next = S_COMWAKE;
                    else if (w_timeout) begin w_next = S_IDLE; w_timeout_evt = 1'b1; end
      S_COMWAKE:    w_next = w_abort ? w_abort_st : S_WAIT_QUIET;
      S_WAIT_QUIET: if (w_abort) w_next = w_abort_st;
                    else if (!rxelecidle_in) w_next = S_ALIGN;
                    else if (w_timeout) begin w_next = S_IDLE; w_timeout_evt = 1'b1; end
      S_ALIGN:      if (w_abort) w_next = w_abort_st;
                    else if (w_rx_align) w_next = S_SYNC;
                    else if (w_timeout) begin w_next = S_IDLE; w_timeout_evt = 1'b1; end
      S_SYNC:       if (w_abort) w_next = w_abort_st;
                    else if (w_prim_nonalign && r_sync_cnt == 2'd2) w_next = S_READY;
                    else if (w_timeout) begin w_next = S_IDLE; w_timeout_evt = 1'b1; end
      S_READY:      if (w_abort) w_next = w_abort_st;
                    else if (w_idle_loss) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_sync_cnt    <= '0;
      r_idle_cnt    <= '0;
      txcominit     <= 1'b0;
      txcomwake     <= 1'b0;
      txelecidle    <= 1'b1;
      txdata_out    <= '0;
      txcharisk_out <= '0;
      link_up       <= 1'b0;
      link_down     <= 1'b0;
      oob_error     <= 1'b0;
      phy_ready     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= (w_next != r_state) ? '0 : (w_waiting ? r_cnt + 20'd1 : r_cnt);
      r_sync_cnt <= (r_state == S_SYNC && w_next == S_SYNC && w_prim_nonalign) ?
                    r_sync_cnt + 2'd1 : '0;
      r_idle_cnt <= (r_state == S_READY && w_next == S_READY && rxelecidle_in) ?
                    r_idle_cnt + IW'(1) : '0;
      // Outputs are decoded from the state being entered so they line up with it.
      txcominit  <= (w_next == S_COMINIT);
      txcomwake  <= (w_next == S_COMWAKE);
      txelecidle <= !(w_next inside {S_ALIGN, S_SYNC, S_READY});
      case (w_next)
        S_ALIGN: begin txdata_out <= ALIGNP;    txcharisk_out <= K_PRIM;       end
        S_SYNC:  begin txdata_out <= SYNCP;     txcharisk_out <= K_PRIM;       end
        S_READY: begin txdata_out <= txdata_in; txcharisk_out <= txcharisk_in; end
        default: begin txdata_out <= '0;        txcharisk_out <= '0;           end
      endcase
      link_up   <= (r_state == S_SYNC) && (w_next == S_READY);
      link_down <= (r_state == S_READY) && (w_next != S_READY);
      oob_error <= w_timeout_evt;
      phy_ready <= (w_next == S_READY) && gtx_ready && rxbyteisaligned;
    end
  end

`ifdef OOB_DEV_DEBUG_EN
  logic [3:0] r_dbg_comreset;
  logic [2:0] r_dbg_timeout;
  logic       r_dbg_aligned;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dbg_comreset <= '0;
      r_dbg_timeout  <= '0;
      r_dbg_aligned  <= 1'b0;
    end else begin
      if (w_next == S_COMINIT && r_state != S_COMINIT && r_dbg_comreset != 4'hF)
        r_dbg_comreset <= r_dbg_comreset + 4'd1;
      if (w_timeout_evt && r_dbg_timeout != 3'h7)
        r_dbg_timeout <= r_dbg_timeout + 3'd1;
      r_dbg_aligned <= rxbyteisaligned;
    end
  end

  assign debug = {r_dbg_aligned, r_dbg_timeout, r_dbg_comreset, r_state};
`else
  assign debug = '0;
`endif

endmodule

// File: tb/tb_oob_dev.sv
// Directed bench for oob_dev: OOB handshake, ALIGN/SYNC lock, READY pass-through, loss and timeout paths.
module tb_oob_dev;

  localparam int LIMIT = 66000;
  localparam logic [31:0] ALIGNP = 32'h7B4A4ABC;
  localparam logic [31:0] SYNCP  = 32'hB5B5957C;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gtx_ready;
  logic        rxcominitdet_in;
  logic        rxcomwakedet_in;
  logic        rxelecidle_in;
  logic        txcominit;
  logic        txcomwake;
  logic        txelecidle;
  logic [31:0] txdata_in;
  logic [3:0]  txcharisk_in;
  logic [31:0] txdata_out;
  logic [3:0]  txcharisk_out;
  logic [31:0] rxdata_in;
  logic [3:0]  rxcharisk_in;
  logic        rxbyteisaligned;
  logic        link_up;
  logic        link_down;
  logic        oob_error;
  logic        phy_ready;
  logic [11:0] debug;

  logic [35:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  oob_dev dut (
    .clk(clk), .rst_n(rst_n), .gtx_ready(gtx_ready),
    .rxcominitdet_in(rxcominitdet_in), .rxcomwakedet_in(rxcomwakedet_in),
    .rxelecidle_in(rxelecidle_in), .txcominit(txcominit), .txcomwake(txcomwake),
    .txelecidle(txelecidle), .txdata_in(txdata_in), .txcharisk_in(txcharisk_in),
    .txdata_out(txdata_out), .txcharisk_out(txcharisk_out), .rxdata_in(rxdata_in),
    .rxcharisk_in(rxcharisk_in), .rxbyteisaligned(rxbyteisaligned), .link_up(link_up),
    .link_down(link_down), .oob_error(oob_error), .phy_ready(phy_ready), .debug(debug)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_tx(input logic [3:0] k, input logic [31:0] d);
    exp_q.push_back({k, d});
  endtask

  task automatic check_tx(input string tag);
    logic [35:0] e;
    e = exp_q.pop_front();
    chkw(tag, {txcharisk_out, txdata_out}, e);
  endtask

  task automatic check_reset_vals(input string tag);
    chk1({tag, "_txelecidle"}, txelecidle, 1'b1);
    chk1({tag, "_txcominit"}, txcominit, 1'b0);
    chk1({tag, "_txcomwake"}, txcomwake, 1'b0);
    chkw({tag, "_tx"}, {txcharisk_out, txdata_out}, 36'h0);
    chk1({tag, "_link_up"}, link_up, 1'b0);
    chk1({tag, "_link_down"}, link_down, 1'b0);
    chk1({tag, "_oob_error"}, oob_error, 1'b0);
    chk1({tag, "_phy_ready"}, phy_ready, 1'b0);
    chkw({tag, "_debug"}, 36'(debug), 36'h0);
  endtask

  // From IDLE (or any post-IDLE state): COMRESET pulse, ends in WAIT_WAKE.
  task automatic do_comreset(input string tag);
    rxelecidle_in   = 1'b1;
    rxcominitdet_in = 1'b1;
    tick();
    chk1({tag, "_txcominit"}, txcominit, 1'b1);
    chk1({tag, "_cominit_elecidle"}, txelecidle, 1'b1);
    rxcominitdet_in = 1'b0;
    tick();
    chk1({tag, "_txcominit_end"}, txcominit, 1'b0);
  endtask

  // From WAIT_WAKE: COMWAKE, line goes active, ends in ALIGN.
  task automatic do_wake_to_align(input string tag);
    rxcomwakedet_in = 1'b1;
    tick();
    chk1({tag, "_txcomwake"}, txcomwake, 1'b1);
    rxcomwakedet_in = 1'b0;
    tick();
    chk1({tag, "_txcomwake_end"}, txcomwake, 1'b0);
    chk1({tag, "_quiet_elecidle"}, txelecidle, 1'b1);
    rxelecidle_in = 1'b0;
    expect_tx(4'b0001, ALIGNP);
    tick();
    check_tx({tag, "_align_tx"});
    chk1({tag, "_align_elecidle"}, txelecidle, 1'b0);
  endtask

  // From ALIGN: host ALIGNp x4, then SYNCp run (optionally broken by an ALIGNp).
  task automatic sync_to_ready(input string tag, input bit broken);
    int n;
    logic [31:0] w;
    rxbyteisaligned = 1'b1;
    rxcharisk_in    = 4'b0001;
    rxdata_in       = ALIGNP;
    for (int i = 0; i < 4; i++) begin
      expect_tx(4'b0001, SYNCP);
      tick();
      check_tx({tag, "_sync_tx"});
      chk1({tag, "_no_link_up_align"}, link_up, 1'b0);
    end
    txdata_in    = $urandom;
    txcharisk_in = 4'($urandom_range(0, 15));
    n = broken ? 6 : 3;
    for (int i = 0; i < n; i++) begin
      w = (broken && i == 2) ? ALIGNP : SYNCP;
      rxdata_in = w;
      if (i == n - 1) expect_tx(txcharisk_in, txdata_in);
      else            expect_tx(4'b0001, SYNCP);
      tick();
      check_tx({tag, "_sync_run_tx"});
      chk1({tag, "_link_up"}, link_up, (i == n - 1));
    end
    chk1({tag, "_phy_ready"}, phy_ready, 1'b1);
    expect_tx(txcharisk_in, txdata_in);
    tick();
    check_tx({tag, "_ready_tx"});
    chk1({tag, "_link_up_once"}, link_up, 1'b0);
  endtask

  initial begin
    int cyc;
    int ld;
    bit seen;
    rst_n           = 1'b0;
    gtx_ready       = 1'b0;
    rxcominitdet_in = 1'b0;
    rxcomwakedet_in = 1'b0;
    rxelecidle_in   = 1'b1;
    txdata_in       = '0;
    txcharisk_in    = '0;
    rxdata_in       = '0;
    rxcharisk_in    = '0;
    rxbyteisaligned = 1'b0;
    tick();
    tick();
    check_reset_vals("reset");
    rst_n     = 1'b1;
    gtx_ready = 1'b1;
    tick();
    chk1("idle_txelecidle", txelecidle, 1'b1);

    // Nominal link-up, with a repeated COMRESET while waiting for COMWAKE
    do_comreset("nom");
    repeat (5) tick();
    rxcominitdet_in = 1'b1;
    tick();
    chk1("wait_wake_recomreset", txcominit, 1'b1);
    rxcominitdet_in = 1'b0;
    tick();
    repeat (49) tick();
    do_wake_to_align("nom");
    sync_to_ready("nom", 1'b0);

    // READY pass-through of random link-layer words
    for (int i = 0; i < 6; i++) begin
      txdata_in    = $urandom;
      txcharisk_in = 4'($urandom_range(0, 15));
      expect_tx(txcharisk_in, txdata_in);
      tick();
      check_tx("ready_pass");
    end

    // COMRESET while in READY
    rxcominitdet_in = 1'b1;
    tick();
    chk1("rdy_comreset_link_down", link_down, 1'b1);
    chk1("rdy_comreset_phy_ready", phy_ready, 1'b0);
    chk1("rdy_comreset_txcominit", txcominit, 1'b1);
    rxcominitdet_in = 1'b0;
    rxelecidle_in   = 1'b1;
    tick();
    chk1("rdy_comreset_link_down_end", link_down, 1'b0);
    chk1("rdy_comreset_txcominit_end", txcominit, 1'b0);

    // Broken SYNC run
    do_wake_to_align("brk");
    sync_to_ready("brk", 1'b1);

    // Line idle in READY: 63 cycles tolerated, 64 drop the link
    ld = 0;
    rxelecidle_in = 1'b1;
    repeat (63) begin tick(); ld += int'(link_down); end
    chkw("idle63_no_link_down", 36'(ld), 36'd0);
    chk1("idle63_phy_ready", phy_ready, 1'b1);
    rxelecidle_in = 1'b0;
    tick();
    chk1("idle_gap_phy_ready", phy_ready, 1'b1);
    ld = 0;
    rxelecidle_in = 1'b1;
    repeat (63) begin tick(); ld += int'(link_down); end
    chkw("idle64_pre_no_link_down", 36'(ld), 36'd0);
    tick();
    chk1("idle64_link_down", link_down, 1'b1);
    chk1("idle64_txelecidle", txelecidle, 1'b1);
    chk1("idle64_phy_ready", phy_ready, 1'b0);
    chkw("idle64_tx", {txcharisk_out, txdata_out}, 36'h0);
    tick();
    chk1("idle64_link_down_end", link_down, 1'b0);

    // Reset while in ALIGN
    rxdata_in    = '0;
    rxcharisk_in = '0;
    do_comreset("rst");
    do_wake_to_align("rst");
    rst_n = 1'b0;
    tick();
    check_reset_vals("rst_align");
    rst_n = 1'b1;
    tick();
    chk1("rst_release_txelecidle", txelecidle, 1'b1);
    chk1("rst_release_oob_error", oob_error, 1'b0);

    // No COMWAKE: timeout after LIMIT cycles in WAIT_WAKE
    rxbyteisaligned = 1'b0;
    do_comreset("to");
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < LIMIT + 10) begin
      tick();
      cyc++;
      if (oob_error) seen = 1'b1;
    end
    chkw("timeout_cycle", 36'(cyc), 36'(LIMIT));
    chk1("timeout_txelecidle", txelecidle, 1'b1);
    rxcomwakedet_in = 1'b1;
    tick();
    chk1("timeout_oob_error_end", oob_error, 1'b0);
    chk1("timeout_in_idle_no_comwake", txcomwake, 1'b0);
    rxcomwakedet_in = 1'b0;
    tick();

`ifndef OOB_DEV_DEBUG_EN
    chkw("debug_tied_low", 36'(debug), 36'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
